id_issue_queue: RTL and testbench
=================================

Name: id_issue_queue

Overview:
- Parametrised decode/issue stage that sits between fetch and execute.
- Buffers fetched {inst, pc} pairs in a DEPTH-entry queue and extracts the rs/rt/rd/imm/sa fields.
- Reads operands through external register-file ports, then resolves them against NUM_FWD forwarding channels.
- Stalls on load-use hazards and issues one instruction per cycle through a registered valid/ready output with flush support.

Parameters:
XLEN, 32, data/PC width
DEPTH, 4, queue entries; power of two, >=2
NUM_FWD, 3, forwarding channels; index 0 = youngest (EX), higher = older
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  fetch offers an instruction
in_ready  out  1  queue can accept
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction PC
flush  in  1  discard queue and output register
rf_ra1  out  5  regfile read address = head rs
rf_ra2  out  5  regfile read address = head rt
rf_rd1  in  XLEN  combinational read data for rf_ra1
rf_rd2  in  XLEN  combinational read data for rf_ra2
fwd_we  in  NUM_FWD  channel k writes a register
fwd_wa  in  5*NUM_FWD  channel k write address, packed [5k+4:5k]
fwd_wd  in  XLEN*NUM_FWD  channel k write data
fwd_isload  in  NUM_FWD  channel k data not yet available (load in flight)
out_valid  out  1  issue register holds an instruction
out_ready  in  1  execute accepts
out_inst  out  32  issued instruction
out_pc  out  XLEN  issued PC
out_rs, out_rt, out_rd  out  5 each  inst[25:21], inst[20:16], inst[15:11]
out_rd1, out_rd2  out  XLEN  resolved operands
out_imm_ext  out  XLEN  inst[15:0] sign-extended
out_sa_ext  out  XLEN  inst[10:6] zero-extended
stall_cnt  out  CNT_W  hazard-stall cycle count

Behaviour:
- Reset:
  - Async assert when rst=0: queue empty (rd/wr pointers 0, count 0), out_valid=0, all out_* data=0, stall_cnt=0.
  - in_ready=1 once rst releases.
- Queue:
  - in_ready = (count < DEPTH); it does not depend on out_ready.
  - Enqueue on in_valid && in_ready.
  - Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- Operand resolution, combinational on the head entry:
  - For each source (rs, rt), the value is 0 if the address is 0.
  - Otherwise take fwd_wd[k] of the lowest k with fwd_we[k] && fwd_wa[k]==addr && !fwd_isload[k].
  - If no channel matches, use rf_rdX.
- Hazard:
  - hazard = head valid && there exists a channel k with fwd_we[k] && fwd_isload[k] && fwd_wa[k]!=0 && fwd_wa[k] is in {rs, rt}.
  - This holds only if no lower-index non-load channel already supplies that address.
- Issue:
  - Fires when head valid && !hazard && (!out_valid || out_ready).
  - On issue: dequeue, and load all out_* registers at the edge; out_valid=1.
  - If out_valid && out_ready && no issue: out_valid=0 and data holds its last value.
  - If out_valid && !out_ready: all out_* hold stable.
- Latency: an instruction accepted at edge E is presented with out_valid=1 after edge E+1 at the earliest (no bypass around the queue).
- Flush:
  - Synchronous. At the edge: count=0, pointers=0, out_valid=0.
  - Any enqueue or issue in the same cycle is discarded (flush has priority).
  - in_ready is unaffected during the flush cycle.
- stall_cnt: increments by 1 in every cycle where hazard=1; saturates at 2^CNT_W-1; not cleared by flush.
- Full queue with a blocked output: in_ready=0 and no entry is lost or overwritten.

Decomposition:
- Shared package:
  - Field slice constants: OP_HI/LO, RS/RT/RD/SA bit positions.
  - REG_ZERO=5'd0.
  - Function sign_ext16(XLEN).
- Sub-module fwd_mux (one per source, instantiated twice).
  - Parametrised by NUM_FWD/XLEN.
  - Outputs the resolved value and a pending-load flag.
- Queue storage and pointer logic stay inline.

Test Plan:
- Reset and streaming: release rst, push inst 0x00221820 (add $3,$1,$2) at pc 0x400 with out_ready=1. Required: out_valid=1 one edge after acceptance, out_rs=1, out_rt=2, out_rd=3, out_rd1/out_rd2 equal rf data.
- Forwarding priority: head rs=5; fwd ch0 wa=5 wd=0xAAAA, ch2 wa=5 wd=0xBBBB, neither load. Required: out_rd1=0xAAAA. Repeat with ch0 we=0: out_rd1=0xBBBB. With rs=0 and ch0 wa=0: out_rd1=0.
- Load-use stall: ch0 we=1, isload=1, wa=rt=7 for 3 cycles, then isload=0 with wd=0x1234. Required: no issue for 3 cycles, stall_cnt=3, then issue with out_rd2=0x1234.
- Backpressure/full: out_ready=0, push DEPTH+2 instructions. Required: out_valid=1, in_ready=0 after DEPTH+1 accepts, out_* stable. Release out_ready: all instructions emerge in order, no loss.
- Flush: queue holds 3 entries, out_valid=1; assert flush together with in_valid. Required: next cycle count=0, out_valid=0, the flush-cycle input is dropped, and a subsequent push issues normally.
- Async reset mid-operation: drop rst between edges with the queue non-empty. Required: out_valid=0 and stall_cnt=0 immediately, before the next edge.

Source files
------------

// File: rtl/id_issue_queue_pkg.sv
// id_issue_queue shared definitions:
// instruction field slices, register constants and helpers.
package id_issue_queue_pkg;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int SA_HI  = 10;
    localparam int SA_LO  = 6;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Widest supported data path; callers truncate to their XLEN.
    localparam int EXT_W = 64;

    function automatic logic [EXT_W-1:0] sign_ext16(input logic [15:0] imm);
        return {{(EXT_W-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/id_issue_queue_fwd_mux.sv
// Operand resolver for one source register:
// zero register, youngest non-load forward, else regfile.
module id_issue_queue_fwd_mux
    import id_issue_queue_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 3
) (
    input  logic [4:0]              addr,
    input  logic [XLEN-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [5*NUM_FWD-1:0]    fwd_wa,
    input  logic [XLEN*NUM_FWD-1:0] fwd_wd,
    input  logic [NUM_FWD-1:0]      fwd_isload,
    output logic [XLEN-1:0]         value,
    output logic                    pending
);

    logic hit;

    // Scan youngest-first; a load seen before any real hit is a hazard.
    always_comb begin
        value   = rf_data;
        pending = 1'b0;
        hit     = 1'b0;
        if (addr == REG_ZERO) begin
            value = '0;
        end else begin
            for (int k = 0; k < NUM_FWD; k++) begin
                if (!hit && fwd_we[k] && fwd_wa[5*k +: 5] == addr) begin
                    if (fwd_isload[k]) begin
                        pending = 1'b1;
                    end else begin
                        value = fwd_wd[XLEN*k +: XLEN];
                        hit   = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/id_issue_queue.sv
// Decode/issue stage: instruction queue, operand resolution,
// load-use stall and a registered valid/ready issue slot.
module id_issue_queue
    import id_issue_queue_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_inst,
    input  logic [XLEN-1:0]         in_pc,
    input  logic                    flush,
    output logic [4:0]              rf_ra1,
    output logic [4:0]              rf_ra2,
    input  logic [XLEN-1:0]         rf_rd1,
    input  logic [XLEN-1:0]         rf_rd2,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [5*NUM_FWD-1:0]    fwd_wa,
    input  logic [XLEN*NUM_FWD-1:0] fwd_wd,
    input  logic [NUM_FWD-1:0]      fwd_isload,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_inst,
    output logic [XLEN-1:0]         out_pc,
    output logic [4:0]              out_rs,
    output logic [4:0]              out_rt,
    output logic [4:0]              out_rd,
    output logic [XLEN-1:0]         out_rd1,
    output logic [XLEN-1:0]         out_rd2,
    output logic [XLEN-1:0]         out_imm_ext,
    output logic [XLEN-1:0]         out_sa_ext,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]     q_inst [DEPTH];
    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [31:0]     head_inst;
    logic [XLEN-1:0] head_pc;
    logic            head_valid;
    logic            enq;
    logic            issue;
    logic            hazard;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            pend1;
    logic            pend2;

    assign head_inst  = q_inst[rd_ptr];
    assign head_pc    = q_pc[rd_ptr];
    assign head_valid = (count != '0);
    assign in_ready   = (count < FULL);
    assign rf_ra1     = head_inst[RS_HI:RS_LO];
    assign rf_ra2     = head_inst[RT_HI:RT_LO];

    // Flush wins over both queue write and issue in the same cycle.
    assign hazard = head_valid && (pend1 || pend2);
    assign issue  = head_valid && !hazard && (!out_valid || out_ready) && !flush;
    assign enq    = in_valid && in_ready && !flush;

    id_issue_queue_fwd_mux #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
    ) u_mux_rs (
        .addr       (rf_ra1),
        .rf_data    (rf_rd1),
        .fwd_we     (fwd_we),
        .fwd_wa     (fwd_wa),
        .fwd_wd     (fwd_wd),
        .fwd_isload (fwd_isload),
        .value      (op1),
        .pending    (pend1)
    );

    id_issue_queue_fwd_mux #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
    ) u_mux_rt (
        .addr       (rf_ra2),
        .rf_data    (rf_rd2),
        .fwd_we     (fwd_we),
        .fwd_wa     (fwd_wa),
        .fwd_wd     (fwd_wd),
        .fwd_isload (fwd_isload),
        .value      (op2),
        .pending    (pend2)
    );

    // Queue storage: write the tail slot on enqueue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (enq) begin
            q_inst[wr_ptr] <= in_inst;
            q_pc[wr_ptr]   <= in_pc;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({enq, issue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue slot: load on issue, drop valid once consumed, else hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_inst    <= '0;
            out_pc      <= '0;
            out_rs      <= '0;
            out_rt      <= '0;
            out_rd      <= '0;
            out_rd1     <= '0;
            out_rd2     <= '0;
            out_imm_ext <= '0;
            out_sa_ext  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid   <= 1'b1;
            out_inst    <= head_inst;
            out_pc      <= head_pc;
            out_rs      <= head_inst[RS_HI:RS_LO];
            out_rt      <= head_inst[RT_HI:RT_LO];
            out_rd      <= head_inst[RD_HI:RD_LO];
            out_rd1     <= op1;
            out_rd2     <= op2;
            out_imm_ext <= XLEN'(sign_ext16(head_inst[IMM_HI:IMM_LO]));
            out_sa_ext  <= {{(XLEN-5){1'b0}}, head_inst[SA_HI:SA_LO]};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Hazard cycle counter, saturating, survives flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (hazard && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_issue_queue.sv
// Scoreboard bench for id_issue_queue: a queue-level reference
// model predicts each issue; a negedge monitor checks the output.
module tb_id_issue_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int NF    = 3;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [XLEN-1:0]   in_pc;
    logic              flush;
    logic [4:0]        rf_ra1;
    logic [4:0]        rf_ra2;
    logic [XLEN-1:0]   rf_rd1;
    logic [XLEN-1:0]   rf_rd2;
    logic [NF-1:0]     fwd_we;
    logic [5*NF-1:0]   fwd_wa;
    logic [XLEN*NF-1:0] fwd_wd;
    logic [NF-1:0]     fwd_isload;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [XLEN-1:0]   out_pc;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_rd;
    logic [XLEN-1:0]   out_rd1;
    logic [XLEN-1:0]   out_rd2;
    logic [XLEN-1:0]   out_imm_ext;
    logic [XLEN-1:0]   out_sa_ext;
    logic [CNT_W-1:0]  stall_cnt;

    id_issue_queue #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .NUM_FWD (NF),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .flush       (flush),
        .rf_ra1      (rf_ra1),
        .rf_ra2      (rf_ra2),
        .rf_rd1      (rf_rd1),
        .rf_rd2      (rf_rd2),
        .fwd_we      (fwd_we),
        .fwd_wa      (fwd_wa),
        .fwd_wd      (fwd_wd),
        .fwd_isload  (fwd_isload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_rs      (out_rs),
        .out_rt      (out_rt),
        .out_rd      (out_rd),
        .out_rd1     (out_rd1),
        .out_rd2     (out_rd2),
        .out_imm_ext (out_imm_ext),
        .out_sa_ext  (out_sa_ext),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    logic        f_we [NF];
    logic [4:0]  f_wa [NF];
    logic [31:0] f_wd [NF];
    logic        f_ld [NF];
    logic [31:0] regs [32];

    always_comb begin
        fwd_we     = '0;
        fwd_wa     = '0;
        fwd_wd     = '0;
        fwd_isload = '0;
        for (int k = 0; k < NF; k++) begin
            fwd_we[k]          = f_we[k];
            fwd_wa[5*k +: 5]   = f_wa[k];
            fwd_wd[32*k +: 32] = f_wd[k];
            fwd_isload[k]      = f_ld[k];
        end
    end

    assign rf_rd1 = regs[rf_ra1];
    assign rf_rd2 = regs[rf_ra2];

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } exp_t;

    ent_t        mq [$];
    exp_t        exp_q [$];
    exp_t        mon_e;
    bit          m_ov;
    int unsigned m_stall;
    bit          drop_front;
    int          checks;
    int          failures;
    int          n_out;
    int          n0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] resolve(input logic [4:0] a,
                                            input logic [31:0] rfv);
        if (a == 5'd0) return 32'd0;
        for (int k = 0; k < NF; k++)
            if (f_we[k] && f_wa[k] == a && !f_ld[k]) return f_wd[k];
        return rfv;
    endfunction

    function automatic bit load_hazard(input logic [4:0] rs,
                                       input logic [4:0] rt);
        for (int k = 0; k < NF; k++) begin
            if (f_we[k] && f_ld[k] && f_wa[k] != 5'd0 &&
                (f_wa[k] == rs || f_wa[k] == rt)) begin
                bit covered = 0;
                for (int j = 0; j < k; j++)
                    if (f_we[j] && !f_ld[j] && f_wa[j] == f_wa[k])
                        covered = 1;
                if (!covered) return 1;
            end
        end
        return 0;
    endfunction

    task automatic model_eval();
        bit   hz;
        bit   iss;
        bit   enq;
        ent_t h;
        exp_t e;
        chk("out_valid", out_valid, m_ov);
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("stall_cnt", stall_cnt, m_stall);
        hz  = 0;
        iss = 0;
        h   = '0;
        enq = in_valid && (mq.size() < DEPTH) && !flush;
        if (mq.size() > 0) begin
            h   = mq[0];
            hz  = load_hazard(h.inst[25:21], h.inst[20:16]);
            iss = !hz && (!m_ov || out_ready) && !flush;
        end
        if (hz && m_stall < 65535) m_stall++;
        if (flush) begin
            mq.delete();
            if (m_ov && !out_ready) drop_front = 1;
            m_ov = 0;
        end else begin
            if (iss) begin
                e.inst = h.inst;
                e.pc   = h.pc;
                e.rd1  = resolve(h.inst[25:21], regs[h.inst[25:21]]);
                e.rd2  = resolve(h.inst[20:16], regs[h.inst[20:16]]);
                exp_q.push_back(e);
                void'(mq.pop_front());
                m_ov = 1;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (enq) mq.push_back('{in_inst, in_pc});
        end
    endtask

    // Monitor: compare the presented slot with the oldest prediction.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_out: got out_valid=1 expected none");
            end else begin
                mon_e = exp_q[0];
                chk("out_inst", out_inst, mon_e.inst);
                chk("out_pc", out_pc, mon_e.pc);
                chk("out_rs", out_rs, mon_e.inst[25:21]);
                chk("out_rt", out_rt, mon_e.inst[20:16]);
                chk("out_rd", out_rd, mon_e.inst[15:11]);
                chk("out_rd1", out_rd1, mon_e.rd1);
                chk("out_rd2", out_rd2, mon_e.rd2);
                chk("out_imm", out_imm_ext,
                    {{16{mon_e.inst[15]}}, mon_e.inst[15:0]});
                chk("out_sa", out_sa_ext, {27'd0, mon_e.inst[10:6]});
                if (out_ready) n_out++;
                if (out_ready || drop_front) void'(exp_q.pop_front());
            end
        end
        drop_front = 0;
    end

    task automatic step();
        #1;
        model_eval();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] p);
        in_valid = 1'b1;
        in_inst  = i;
        in_pc    = p;
    endtask

    task automatic fwd_off();
        for (int k = 0; k < NF; k++) begin
            f_we[k] = 1'b0;
            f_wa[k] = 5'd0;
            f_wd[k] = 32'd0;
            f_ld[k] = 1'b0;
        end
    endtask

    task automatic rand_cycle(inout logic [31:0] pc);
        in_valid  = ($urandom_range(0, 3) != 0);
        in_inst   = {6'($urandom), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 16'($urandom)};
        pc        = pc + 32'd4;
        in_pc     = pc;
        out_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 49) == 0);
        for (int k = 0; k < NF; k++) begin
            f_we[k] = 1'($urandom_range(0, 1));
            f_wa[k] = 5'($urandom_range(0, 7));
            f_wd[k] = $urandom;
            f_ld[k] = ($urandom_range(0, 4) == 0);
        end
        regs[$urandom_range(1, 31)] = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        checks     = 0;
        failures   = 0;
        n_out      = 0;
        m_ov       = 0;
        m_stall    = 0;
        drop_front = 0;
        in_valid   = 0;
        in_inst    = 0;
        in_pc      = 0;
        flush      = 0;
        out_ready  = 0;
        fwd_off();
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i * 32'h0101;
        regs[0] = 32'hDEAD_0000;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_rd1", out_rd1, 0);
        rst = 1'b1;
        #0;
        chk("rst_in_ready", in_ready, 1);

        out_ready = 1'b1;
        push(32'h0022_1820, 32'h400);
        step();
        in_valid = 1'b0;
        chk("lat_early", out_valid, 0);
        step();
        chk("stream_valid", out_valid, 1);
        chk("stream_rs", out_rs, 1);
        chk("stream_rt", out_rt, 2);
        chk("stream_rd", out_rd, 3);
        chk("stream_rd1", out_rd1, regs[1]);
        chk("stream_rd2", out_rd2, regs[2]);
        chk("stream_pc", out_pc, 32'h400);
        step();

        f_we[0] = 1; f_wa[0] = 5; f_wd[0] = 32'hAAAA;
        f_we[2] = 1; f_wa[2] = 5; f_wd[2] = 32'hBBBB;
        push(32'h00A6_3800, 32'h500);
        step();
        in_valid = 1'b0;
        step();
        chk("fwd_ch0", out_rd1, 32'hAAAA);
        f_we[0] = 0;
        push(32'h00A6_3800, 32'h504);
        step();
        in_valid = 1'b0;
        step();
        chk("fwd_ch2", out_rd1, 32'hBBBB);
        f_we[0] = 1; f_wa[0] = 0;
        push(32'h0006_3800, 32'h508);
        step();
        in_valid = 1'b0;
        step();
        chk("fwd_zero", out_rd1, 0);
        fwd_off();
        step();

        push(32'h0027_1800, 32'h600);
        step();
        in_valid = 1'b0;
        f_we[0] = 1; f_ld[0] = 1; f_wa[0] = 7;
        repeat (3) begin
            step();
            chk("stall_hold", out_valid, 0);
        end
        chk("stall_cnt3", stall_cnt, 3);
        f_ld[0] = 0; f_wd[0] = 32'h1234;
        step();
        chk("ldu_issue", out_valid, 1);
        chk("ldu_rd2", out_rd2, 32'h1234);
        chk("ldu_cnt", stall_cnt, 3);
        fwd_off();
        step();

        out_ready = 1'b0;
        n0 = n_out;
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(32'h0042_0000 + i, 32'h700 + 4 * i);
            step();
        end
        in_valid = 1'b0;
        chk("full_ready", in_ready, 0);
        chk("full_valid", out_valid, 1);
        repeat (3) step();
        chk("full_hold", out_inst, 32'h0042_0000);
        out_ready = 1'b1;
        repeat (DEPTH + 4) step();
        chk("drain_count", n_out - n0, DEPTH + 1);
        chk("drain_idle", out_valid, 0);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(32'h0062_0000 + i, 32'h800 + 4 * i);
            step();
        end
        flush = 1'b1;
        push(32'h0063_0000, 32'h880);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) step();
        chk("flush_dropped", out_valid, 0);
        push(32'h0064_0800, 32'h900);
        step();
        in_valid = 1'b0;
        step();
        chk("post_flush_valid", out_valid, 1);
        chk("post_flush_inst", out_inst, 32'h0064_0800);
        step();

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(32'h0065_0000 + i, 32'hA00 + 4 * i);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_stall", stall_cnt, 0);
        chk("arst_inst", out_inst, 0);
        chk("arst_ready", in_ready, 1);
        mq.delete();
        exp_q.delete();
        m_ov       = 0;
        m_stall    = 0;
        drop_front = 0;
        rst = 1'b1;
        model_eval();
        @(posedge clk);
        #2;

        pc = 32'h1000;
        repeat (3000) begin
            rand_cycle(pc);
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        fwd_off();
        repeat (DEPTH + 4) step();
        chk("final_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
